// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage: load/store unit on a req/gnt/rvalid data-memory bus,
// followed by the MEM/WB register.
module mem_stage_lsu #(
    parameter int XLEN         = 32,
    parameter int WB_SEL_WIDTH = 2,
    parameter int MAX_WAIT     = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_mem,
    input  logic [XLEN-1:0]         pc_mem,
    input  logic [XLEN-1:0]         instr_mem,
    input  logic [XLEN-1:0]         alu_mem,
    input  logic [XLEN-1:0]         rs2_mem,
    input  logic                    mem_rd,
    input  logic                    mem_wr,
    input  logic [WB_SEL_WIDTH-1:0] wb_sel,
    output logic                    stall_mem,
    output logic                    dmem_req,
    output logic                    dmem_we,
    output logic [XLEN-1:0]         dmem_addr,
    output logic [XLEN/8-1:0]       dmem_be,
    output logic [XLEN-1:0]         dmem_wdata,
    input  logic                    dmem_gnt,
    input  logic                    dmem_rvalid,
    input  logic [XLEN-1:0]         dmem_rdata,
    output logic                    valid_wb,
    output logic [XLEN-1:0]         mem_wb,
    output logic [XLEN-1:0]         instr_wb,
    output logic [1:0]              exc_wb
);
    localparam int NB = XLEN / 8;

    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, RESP = 2'd2} state_t;

    state_t     state, state_nxt;
    logic [3:0] wait_cnt, wait_cnt_nxt;

    logic                    we_p1;
    logic [2:0]              f3_p1;
    logic [XLEN-1:0]         addr_p1, wdata_p1, pc_p1, instr_p1;
    logic [NB-1:0]           be_p1;
    logic [WB_SEL_WIDTH-1:0] wb_sel_p1;

    logic            capture, wb_load, wb_valid_nxt;
    logic [1:0]      wb_exc_nxt;
    logic [XLEN-1:0] wb_data_nxt, wb_instr_nxt;
    logic [2:0]      f3;
    logic [1:0]      alo;
    logic            is_mem, mis, issue;

    function automatic logic [NB-1:0] be_gen(input logic [2:0] fn, input logic [1:0] a);
        case (fn[1:0])
            2'b00:   be_gen = NB'(1) << a;
            2'b01:   be_gen = NB'(3) << a;
            default: be_gen = '1;
        endcase
    endfunction

    function automatic logic misaligned(input logic [2:0] fn, input logic [1:0] a);
        case (fn[1:0])
            2'b00:   misaligned = 1'b0;
            2'b01:   misaligned = a[0];
            default: misaligned = |a;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] store_data(input logic [2:0] fn, input logic [XLEN-1:0] rs2);
        case (fn[1:0])
            2'b00:   store_data = {NB{rs2[7:0]}};
            2'b01:   store_data = {(NB/2){rs2[15:0]}};
            default: store_data = rs2;
        endcase
    endfunction

    // funct3[2] selects zero extension (LBU/LHU); signed locals sign-extend through the cast
    function automatic logic [XLEN-1:0] load_ext(input logic [2:0] fn, input logic [1:0] a,
                                                 input logic [XLEN-1:0] rdata);
        logic [XLEN-1:0]    sh;
        logic signed [7:0]  sb;
        logic signed [15:0] shw;
        sh  = rdata >> {a, 3'b000};
        sb  = sh[7:0];
        shw = sh[15:0];
        case (fn[1:0])
            2'b00:   load_ext = fn[2] ? XLEN'(sh[7:0])  : XLEN'(sb);
            2'b01:   load_ext = fn[2] ? XLEN'(sh[15:0]) : XLEN'(shw);
            default: load_ext = rdata;
        endcase
    endfunction

    function automatic logic [XLEN-1:0] wb_mux(input logic [WB_SEL_WIDTH-1:0] sel,
                                               input logic [XLEN-1:0] pc,
                                               input logic [XLEN-1:0] alu,
                                               input logic [XLEN-1:0] mdata);
        if (sel == WB_SEL_WIDTH'(0))      wb_mux = pc + XLEN'(4);
        else if (sel == WB_SEL_WIDTH'(1)) wb_mux = alu;
        else if (sel == WB_SEL_WIDTH'(2)) wb_mux = mdata;
        else                              wb_mux = '0;
    endfunction

    assign f3     = instr_mem[14:12];
    assign alo    = alu_mem[1:0];
    assign is_mem = valid_mem & (mem_rd | mem_wr);
    assign mis    = is_mem & misaligned(f3, alo);
    assign issue  = (state == IDLE) & is_mem & ~mis;

    // MEM stage: bus handshake, stall and WB-register next values
    always_comb begin
        state_nxt    = state;
        wait_cnt_nxt = wait_cnt;
        capture      = 1'b0;
        dmem_req     = 1'b0;
        dmem_we      = 1'b0;
        dmem_addr    = '0;
        dmem_be      = '0;
        dmem_wdata   = '0;
        stall_mem    = 1'b0;
        wb_load      = 1'b0;
        wb_valid_nxt = 1'b0;
        wb_exc_nxt   = 2'd0;
        wb_data_nxt  = '0;
        wb_instr_nxt = '0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (issue) begin
                        dmem_req   = 1'b1;
                        dmem_we    = mem_wr;
                        dmem_addr  = {alu_mem[XLEN-1:2], 2'b00};
                        dmem_be    = be_gen(f3, alo);
                        dmem_wdata = mem_wr ? store_data(f3, rs2_mem) : '0;
                        capture    = 1'b1;
                        if (dmem_gnt && (mem_wr || dmem_rvalid)) begin
                            wb_load      = 1'b1;
                            wb_valid_nxt = 1'b1;
                            wb_instr_nxt = instr_mem;
                            wb_data_nxt  = wb_mux(wb_sel, pc_mem, alu_mem,
                                                  mem_wr ? '0 : load_ext(f3, alo, dmem_rdata));
                        end else begin
                            state_nxt    = dmem_gnt ? RESP : REQ;
                            wait_cnt_nxt = '0;
                            stall_mem    = 1'b1;
                        end
                    end else begin
                        wb_load      = 1'b1;
                        wb_instr_nxt = instr_mem;
                        if (mis) begin
                            wb_valid_nxt = 1'b1;
                            wb_exc_nxt   = 2'd1;
                            wb_data_nxt  = alu_mem;
                        end else begin
                            wb_valid_nxt = valid_mem;
                            wb_data_nxt  = wb_mux(wb_sel, pc_mem, alu_mem, '0);
                        end
                    end
                end
                REQ: begin
                    dmem_req   = 1'b1;
                    dmem_we    = we_p1;
                    dmem_addr  = {addr_p1[XLEN-1:2], 2'b00};
                    dmem_be    = be_p1;
                    dmem_wdata = wdata_p1;
                    if (dmem_gnt && (we_p1 || dmem_rvalid)) begin
                        state_nxt    = IDLE;
                        wb_load      = 1'b1;
                        wb_valid_nxt = 1'b1;
                        wb_instr_nxt = instr_p1;
                        wb_data_nxt  = wb_mux(wb_sel_p1, pc_p1, addr_p1,
                                              we_p1 ? '0 : load_ext(f3_p1, addr_p1[1:0], dmem_rdata));
                    end else if (dmem_gnt) begin
                        state_nxt    = RESP;
                        wait_cnt_nxt = '0;
                        stall_mem    = 1'b1;
                    end else if (wait_cnt == 4'(MAX_WAIT - 1)) begin
                        state_nxt    = IDLE;
                        wb_load      = 1'b1;
                        wb_valid_nxt = 1'b1;
                        wb_exc_nxt   = 2'd2;
                        wb_data_nxt  = addr_p1;
                        wb_instr_nxt = instr_p1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 4'd1;
                        stall_mem    = 1'b1;
                    end
                end
                RESP: begin
                    if (dmem_rvalid) begin
                        state_nxt    = IDLE;
                        wb_load      = 1'b1;
                        wb_valid_nxt = 1'b1;
                        wb_instr_nxt = instr_p1;
                        wb_data_nxt  = wb_mux(wb_sel_p1, pc_p1, addr_p1,
                                              load_ext(f3_p1, addr_p1[1:0], dmem_rdata));
                    end else if (wait_cnt == 4'(MAX_WAIT - 1)) begin
                        state_nxt    = IDLE;
                        wb_load      = 1'b1;
                        wb_valid_nxt = 1'b1;
                        wb_exc_nxt   = 2'd2;
                        wb_data_nxt  = addr_p1;
                        wb_instr_nxt = instr_p1;
                    end else begin
                        wait_cnt_nxt = wait_cnt + 4'd1;
                        stall_mem    = 1'b1;
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    // MEM/WB register boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            wait_cnt <= '0;
            valid_wb <= 1'b0;
            exc_wb   <= 2'd0;
            mem_wb   <= '0;
            instr_wb <= '0;
        end else begin
            state    <= state_nxt;
            wait_cnt <= wait_cnt_nxt;
            valid_wb <= wb_valid_nxt;
            exc_wb   <= wb_exc_nxt;
            if (wb_load) begin
                mem_wb   <= wb_data_nxt;
                instr_wb <= wb_instr_nxt;
            end
        end
    end

    // Request snapshot keeps bus outputs stable while waiting for grant/response
    always_ff @(posedge clk) begin
        if (capture) begin
            we_p1     <= mem_wr;
            f3_p1     <= f3;
            addr_p1   <= alu_mem;
            be_p1     <= be_gen(f3, alo);
            wdata_p1  <= mem_wr ? store_data(f3, rs2_mem) : '0;
            pc_p1     <= pc_mem;
            instr_p1  <= instr_mem;
            wb_sel_p1 <= wb_sel;
        end
    end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Randomized bench for mem_stage_lsu: transaction-level model of each access,
// checked against the DUT every cycle, plus directed literal cases.
module tb_mem_stage_lsu;
    logic        clk = 1'b0;
    logic        rst, valid_mem, mem_rd, mem_wr;
    logic [31:0] pc_mem, instr_mem, alu_mem, rs2_mem;
    logic [1:0]  wb_sel;
    logic        stall_mem, dmem_req, dmem_we;
    logic [31:0] dmem_addr, dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt, dmem_rvalid;
    logic [31:0] dmem_rdata;
    logic        valid_wb;
    logic [31:0] mem_wb, instr_wb;
    logic [1:0]  exc_wb;

    always #5 clk = ~clk;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst), .valid_mem(valid_mem), .pc_mem(pc_mem),
        .instr_mem(instr_mem), .alu_mem(alu_mem), .rs2_mem(rs2_mem),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .wb_sel(wb_sel),
        .stall_mem(stall_mem), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
        .dmem_gnt(dmem_gnt), .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
        .valid_wb(valid_wb), .mem_wb(mem_wb), .instr_wb(instr_wb), .exc_wb(exc_wb)
    );

    int total = 0;
    int bad   = 0;
    int stall_seen = 0;
    int req_seen   = 0;
    logic [3:0]  snap_be;
    logic [31:0] snap_wdata;

    // expectations for the current cycle (bus side) and the WB register
    logic        exp_req, exp_we, exp_stall;
    logic [31:0] exp_addr, exp_wdata;
    logic [3:0]  exp_be;
    logic        exp_vwb;
    logic [31:0] exp_mwb, exp_iwb;
    logic [1:0]  exp_exc;
    // outcome of the current cycle, applied to the WB expectation at the edge
    logic        p_load, p_v;
    logic [31:0] p_m, p_i;
    logic [1:0]  p_e;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h (t=%0t)", nm, act, want, $time);
        end
    endtask

    function automatic int size_of(input logic [2:0] fn);
        if (fn[1:0] == 2'b00) return 1;
        if (fn[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] fn, input logic [31:0] addr,
                                             input logic [31:0] rdata);
        int n;
        logic [31:0] v, mask;
        n = size_of(fn);
        if (n == 4) return rdata;
        mask = (n == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
        v = (rdata >> (8 * (addr % 4))) & mask;
        if (!fn[2] && v[8*n-1]) v = v | ~mask;
        return v;
    endfunction

    function automatic logic [31:0] wb_val(input logic [1:0] sel, input logic [31:0] pc,
                                           input logic [31:0] alu, input logic [31:0] md);
        case (sel)
            2'd0:    return pc + 32'd4;
            2'd1:    return alu;
            2'd2:    return md;
            default: return 32'd0;
        endcase
    endfunction

    task automatic tick();
        @(negedge clk);
        chk("stall_mem", 32'(stall_mem), 32'(exp_stall));
        chk("dmem_req", 32'(dmem_req), 32'(exp_req));
        if (exp_req) begin
            chk("dmem_we", 32'(dmem_we), 32'(exp_we));
            chk("dmem_addr", dmem_addr, exp_addr);
            chk("dmem_be", 32'(dmem_be), 32'(exp_be));
            if (exp_we) chk("dmem_wdata", dmem_wdata, exp_wdata);
        end
        chk("valid_wb", 32'(valid_wb), 32'(exp_vwb));
        chk("mem_wb", mem_wb, exp_mwb);
        chk("instr_wb", instr_wb, exp_iwb);
        chk("exc_wb", 32'(exc_wb), 32'(exp_exc));
        if (stall_mem) stall_seen++;
        if (dmem_req) begin
            req_seen++;
            snap_be = dmem_be;
            snap_wdata = dmem_wdata;
        end
        @(posedge clk);
        #1;
        if (p_load) begin
            exp_mwb = p_m;
            exp_iwb = p_i;
        end
        exp_vwb = p_v;
        exp_exc = p_e;
    endtask

    task automatic nop_op();
        logic v;
        v = 1'($urandom_range(1, 0));
        valid_mem = v;
        mem_rd = v ? 1'b0 : 1'($urandom_range(1, 0));
        mem_wr = 1'b0;
        pc_mem = $urandom; instr_mem = $urandom; alu_mem = $urandom; rs2_mem = $urandom;
        wb_sel = 2'($urandom_range(3, 0));
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        exp_req = 1'b0; exp_stall = 1'b0;
        p_load = 1'b1; p_v = v; p_e = 2'd0; p_i = instr_mem;
        p_m = wb_val(wb_sel, pc_mem, alu_mem, 32'd0);
        tick();
    endtask

    // g: cycle of grant relative to issue; r: cycles from grant to rvalid
    task automatic mem_op(input logic [2:0] fn, input logic we, input logic [31:0] addr,
                          input logic [31:0] rs2, input logic [31:0] rdata,
                          input logic [1:0] sel, input int g, input int r);
        logic [31:0] instr, pc, res, wd;
        logic [3:0]  bem;
        int n, gnt_c, rv_c, end_c, req_last;
        logic tout;
        n = size_of(fn);
        instr = ($urandom & ~32'h0000_7000) | (32'(fn) << 12);
        pc = $urandom;
        valid_mem = 1'b1; mem_rd = ~we; mem_wr = we;
        pc_mem = pc; instr_mem = instr; alu_mem = addr; rs2_mem = rs2; wb_sel = sel;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = $urandom;
        if ((addr % n) != 0) begin
            exp_req = 1'b0; exp_stall = 1'b0;
            p_load = 1'b1; p_v = 1'b1; p_e = 2'd1; p_m = addr; p_i = instr;
            tick();
            return;
        end
        gnt_c    = (g <= 15) ? g : -1;
        req_last = (g <= 15) ? g : 15;
        rv_c     = -1;
        if (g > 15) begin
            end_c = 15; tout = 1'b1;
        end else if (we) begin
            end_c = g; tout = 1'b0;
        end else if (r > 15) begin
            end_c = g + 15; tout = 1'b1;
        end else begin
            end_c = g + r; rv_c = g + r; tout = 1'b0;
        end
        bem = 4'(((1 << n) - 1) << (addr % 4));
        wd  = (n == 1) ? {24'd0, rs2[7:0]} * 32'h0101_0101 :
              (n == 2) ? {16'd0, rs2[15:0]} * 32'h0001_0001 : rs2;
        res = tout ? addr : wb_val(sel, pc, addr, we ? 32'd0 : load_val(fn, addr, rdata));
        for (int c = 0; c <= end_c; c++) begin
            dmem_gnt    = (c == gnt_c);
            dmem_rvalid = (c == rv_c);
            dmem_rdata  = (c == rv_c) ? rdata : $urandom;
            exp_req   = (c <= req_last);
            exp_we    = we;
            exp_addr  = addr & ~32'h3;
            exp_be    = bem;
            exp_wdata = wd;
            exp_stall = (c != end_c);
            if (c == end_c) begin
                p_load = 1'b1; p_v = 1'b1; p_e = tout ? 2'd2 : 2'd0; p_m = res; p_i = instr;
            end else begin
                p_load = 1'b0; p_v = 1'b0; p_e = 2'd0;
            end
            tick();
        end
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=running want=finished");
        $fatal(1, "simulation time limit reached");
    end

    initial begin
        int s0, q0, g, r;
        logic [2:0] fn;
        logic we;
        rst = 1'b1; valid_mem = 1'b0; mem_rd = 1'b0; mem_wr = 1'b0;
        pc_mem = '0; instr_mem = '0; alu_mem = '0; rs2_mem = '0; wb_sel = '0;
        dmem_gnt = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = '0;
        exp_req = 0; exp_we = 0; exp_stall = 0; exp_addr = '0; exp_wdata = '0; exp_be = '0;
        exp_vwb = 0; exp_mwb = '0; exp_iwb = '0; exp_exc = '0;
        p_load = 1; p_v = 0; p_m = '0; p_i = '0; p_e = '0;
        @(posedge clk); #1;
        // reset held with a load presented: no request, no stall, WB cleared
        valid_mem = 1'b1; mem_rd = 1'b1; instr_mem = 32'h0000_2003; alu_mem = 32'h40;
        dmem_gnt = 1'b1;
        tick();
        valid_mem = 1'b0; mem_rd = 1'b0; dmem_gnt = 1'b0;
        tick();
        rst = 1'b0;

        // SW 0xDEADBEEF to 0x100, zero wait
        s0 = stall_seen;
        mem_op(3'b010, 1'b1, 32'h100, 32'hDEAD_BEEF, 32'h0, 2'd1, 0, 0);
        chk("t1_be", 32'(snap_be), 32'h0000_000F);
        chk("t1_wdata", snap_wdata, 32'hDEAD_BEEF);
        chk("t1_stalls", 32'(stall_seen - s0), 32'd0);

        // LB at 0x103, grant +2, rvalid +3
        s0 = stall_seen;
        mem_op(3'b000, 1'b0, 32'h103, 32'h0, 32'h80FF_FF7F, 2'd2, 2, 1);
        chk("t2_mem_wb", mem_wb, 32'hFFFF_FF80);
        chk("t2_stalls", 32'(stall_seen - s0), 32'd3);

        // LHU at 0x102
        mem_op(3'b101, 1'b0, 32'h102, 32'h0, 32'h8001_0000, 2'd2, 0, 0);
        chk("t3_be", 32'(snap_be), 32'h0000_000C);
        chk("t3_mem_wb", mem_wb, 32'h0000_8001);

        // misaligned LW
        s0 = stall_seen; q0 = req_seen;
        mem_op(3'b010, 1'b0, 32'h102, 32'h0, 32'h0, 2'd2, 0, 0);
        chk("t4_exc", 32'(exc_wb), 32'd1);
        chk("t4_mem_wb", mem_wb, 32'h102);
        chk("t4_reqs", 32'(req_seen - q0), 32'd0);
        chk("t4_stalls", 32'(stall_seen - s0), 32'd0);

        // load never granted
        s0 = stall_seen; q0 = req_seen;
        mem_op(3'b010, 1'b0, 32'h104, 32'h0, 32'h0, 2'd2, 40, 0);
        chk("t5_exc", 32'(exc_wb), 32'd2);
        chk("t5_valid", 32'(valid_wb), 32'd1);
        chk("t5_stalls", 32'(stall_seen - s0), 32'd15);
        chk("t5_reqs", 32'(req_seen - q0), 32'd16);
        nop_op();

        // reset pulsed while waiting for rvalid
        valid_mem = 1'b1; mem_rd = 1'b1; mem_wr = 1'b0; wb_sel = 2'd2;
        instr_mem = 32'h0000_2083; alu_mem = 32'h200; pc_mem = 32'h80;
        dmem_gnt = 1'b1; dmem_rvalid = 1'b0;
        exp_req = 1'b1; exp_we = 1'b0; exp_addr = 32'h200; exp_be = 4'hF; exp_stall = 1'b1;
        p_load = 1'b0; p_v = 1'b0; p_e = 2'd0;
        tick();
        rst = 1'b1; valid_mem = 1'b0; mem_rd = 1'b0; dmem_gnt = 1'b0;
        exp_req = 1'b0; exp_stall = 1'b0;
        p_load = 1'b1; p_v = 1'b0; p_m = 32'd0; p_i = 32'd0; p_e = 2'd0;
        tick();
        rst = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = 32'h1234_5678;
        p_load = 1'b1; p_v = 1'b0; p_e = 2'd0; p_i = instr_mem;
        p_m = wb_val(wb_sel, pc_mem, alu_mem, 32'd0);
        tick();
        chk("t6_valid", 32'(valid_wb), 32'd0);
        dmem_rvalid = 1'b0;
        nop_op();

        // randomized mix
        for (int k = 0; k < 300; k++) begin
            int kind;
            kind = int'($urandom_range(9, 0));
            if (kind < 3) begin
                nop_op();
            end else begin
                we = (kind >= 7);
                if (we) fn = 3'($urandom_range(2, 0));
                else begin
                    case ($urandom_range(4, 0))
                        0: fn = 3'b000;
                        1: fn = 3'b001;
                        2: fn = 3'b010;
                        3: fn = 3'b100;
                        default: fn = 3'b101;
                    endcase
                end
                g = ($urandom_range(19, 0) == 0) ? int'($urandom_range(20, 16)) : int'($urandom_range(3, 0));
                if (g == 0 && $urandom_range(2, 0) == 0) r = 0;
                else if ($urandom_range(19, 0) == 0) r = int'($urandom_range(19, 16));
                else r = int'($urandom_range(3, 1));
                mem_op(fn, we, $urandom, $urandom, $urandom, 2'($urandom_range(3, 0)), g, r);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
